tile_config_mem_shadow: RTL and testbench
=========================================

TILE_CONFIG_MEM_SHADOW -- requirements
Module: tile_config_mem_shadow

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 20, frames per column.
REQ-002 SHALL have parameter FrameBitsPerRow, default 32, bits per frame.
REQ-003 SHALL have parameter NoConfigBits, default 640, active config bits; legal range 1..MaxFramesPerCol*FrameBitsPerRow.
REQ-004 SHALL have port UserCLK  input  1  the only clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port FrameData  input  FrameBitsPerRow  frame payload.
REQ-007 SHALL have port FrameStrobe  input  MaxFramesPerCol  per-frame write strobe, level.
REQ-008 SHALL have port CommitReq  input  1  request to copy shadow into active bits.
REQ-009 SHALL have port CommitAck  output  1  commit done; held until CommitReq falls.
REQ-010 SHALL have port ReadbackEn  input  1  readback request.
REQ-011 SHALL have port ReadbackSrc  input  1  0=active, 1=shadow.
REQ-012 SHALL have port ReadbackSel  input  clog2(MaxFramesPerCol)  frame index.
REQ-013 SHALL have port ReadbackData  output  FrameBitsPerRow  registered readback frame.
REQ-014 SHALL have port ReadbackValid  output  1  one-cycle pulse with ReadbackData.
REQ-015 SHALL have port StrobeError  output  1  sticky: multi-hot strobe rise detected.
REQ-016 SHALL have port ConfigBits  output  NoConfigBits  active configuration.
REQ-017 SHALL have port ConfigBits_N  output  NoConfigBits  bitwise inverse of ConfigBits.

Function
REQ-018 Bit mapping SHALL be frame f, bit b <-> index f*FrameBitsPerRow+b; indices >= NoConfigBits SHALL be discarded on write and read as 0.
REQ-019 A frame write SHALL occur on the edge where FrameStrobe[f]=1 and its registered previous value was 0; FrameData at that edge SHALL be stored into shadow frame f.
REQ-020 A strobe held high SHALL write only once; re-write requires a low cycle.
REQ-021 If more than one strobe bit rises on the same edge, no shadow write SHALL occur and StrobeError SHALL set until Reset.
REQ-022 FSM states: IDLE (shadow == active), DIRTY (uncommitted writes), COMMIT (one cycle), ACK.
REQ-023 IDLE->DIRTY on any frame write; IDLE or DIRTY ->COMMIT when CommitReq=1; COMMIT->ACK unconditionally; ACK->IDLE when CommitReq=0 (or ->DIRTY if a write occurred during COMMIT/ACK).
REQ-024 On the edge leaving COMMIT, active SHALL load the shadow content present at the start of the COMMIT cycle; a write landing on that same edge goes to shadow only.
REQ-025 CommitAck SHALL be 1 exactly while in ACK; CommitReq from IDLE with no writes SHALL still complete the handshake.
REQ-026 Frame writes SHALL be accepted in every state.
REQ-027 ReadbackEn=1 at edge N SHALL give ReadbackData of the selected source/frame and ReadbackValid=1 after edge N (latency 1); ReadbackSel >= MaxFramesPerCol SHALL return all-zero with ReadbackValid=1.
REQ-028 ConfigBits SHALL change only on the COMMIT edge or Reset.

Reset
REQ-029 Reset SHALL asynchronously clear shadow, active, strobe history, ReadbackData, ReadbackValid, StrobeError, CommitAck; FSM to IDLE; ConfigBits=0, ConfigBits_N all ones.
REQ-030 Reset during COMMIT/ACK SHALL abort; CommitAck SHALL drop immediately.

Structure
REQ-031 FSM state enum and frame-index width function SHALL live in shared package tile_config_pkg.
REQ-032 Edge detection plus multi-hot check SHALL be sub-module frame_strobe_detect.

Verification
REQ-033 Strobe frame 0 with 0xA5A5A5A5, no commit -> ConfigBits stays 0; shadow readback frame 0 = 0xA5A5A5A5 one cycle after ReadbackEn.
REQ-034 Then CommitReq=1 -> CommitAck after 2 edges, ConfigBits[31:0]=0xA5A5A5A5, ConfigBits_N[31:0]=0x5A5A5A5A; ack drops one cycle after CommitReq low.
REQ-035 FrameStrobe=0x3 rising together -> no write, StrobeError=1 until Reset.
REQ-036 Strobe frame 1 on COMMIT edge -> active frame 1 unchanged, FSM ends in DIRTY after ack.
REQ-037 Reset asserted in ACK -> CommitAck=0 and ConfigBits=0 before next clock edge.
REQ-038 NoConfigBits=40, write 0xFFFFFFFF to frame 1 -> ConfigBits[39:32]=0xFF; active readback frame 1 = 0x000000FF; ReadbackSel=25 -> 0.

Source files
------------

// File: rtl/tile_config_pkg.sv
// Shared types for the tile configuration shadow memory: commit FSM states
// and the frame-index width helper used for the readback select port.
package tile_config_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDirty  = 2'd1,
        StCommit = 2'd2,
        StAck    = 2'd3
    } commitState_e;

    // Width of an index addressing `frames` entries; never narrower than 1 bit.
    function automatic int frameIdxWidth(input int frames);
        return (frames > 1) ? $clog2(frames) : 1;
    endfunction

endpackage

// File: rtl/frame_strobe_detect.sv
// Rising-edge detection on the per-frame write strobes. A write is issued only
// when exactly one strobe bit rises on an edge; simultaneous rises are flagged.
module frame_strobe_detect #(
    parameter int Frames = 20
) (
    input  logic              UserCLK,
    input  logic              Reset,
    input  logic [Frames-1:0] FrameStrobe,
    output logic [Frames-1:0] writeOnehot,
    output logic              multiHot
);

    logic [Frames-1:0] strobePrev;
    logic [Frames-1:0] rising;

    // NOTE: registers are always assigned with <= so every flop samples the
    // pre-edge value of its neighbours, independent of block ordering.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            strobePrev <= '0;
        end else begin
            strobePrev <= FrameStrobe;
        end
    end

    assign rising      = FrameStrobe & ~strobePrev;
    // Clearing the lowest set bit leaves something behind only if two or more rose.
    assign multiHot    = (rising & (rising - Frames'(1))) != '0;
    assign writeOnehot = multiHot ? '0 : rising;

endmodule

// File: rtl/tile_config_mem_shadow.sv
// Double-buffered tile configuration: frames are written into a shadow copy
// and moved to the active ConfigBits by a CommitReq/CommitAck handshake.
module tile_config_mem_shadow
    import tile_config_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 640
) (
    input  logic                                      UserCLK,
    input  logic                                      Reset,
    input  logic [FrameBitsPerRow-1:0]                FrameData,
    input  logic [MaxFramesPerCol-1:0]                FrameStrobe,
    input  logic                                      CommitReq,
    output logic                                      CommitAck,
    input  logic                                      ReadbackEn,
    input  logic                                      ReadbackSrc,
    input  logic [frameIdxWidth(MaxFramesPerCol)-1:0] ReadbackSel,
    output logic [FrameBitsPerRow-1:0]                ReadbackData,
    output logic                                      ReadbackValid,
    output logic                                      StrobeError,
    output logic [NoConfigBits-1:0]                   ConfigBits,
    output logic [NoConfigBits-1:0]                   ConfigBits_N
);

    localparam int TotalBits = MaxFramesPerCol * FrameBitsPerRow;
    localparam int PadIdxW   = (TotalBits > 1) ? $clog2(TotalBits) : 1;

    commitState_e              state;
    logic                      pendingWrite;
    logic [NoConfigBits-1:0]   shadow;
    logic [NoConfigBits-1:0]   active;
    logic [MaxFramesPerCol-1:0] writeOnehot;
    logic                      multiHot;
    logic                      anyWrite;
    logic [TotalBits-1:0]      shadowPad;
    logic [TotalBits-1:0]      activePad;
    logic [TotalBits-1:0]      shadowWrPad;
    logic [TotalBits-1:0]      rbSrcPad;
    logic [PadIdxW-1:0]        rbBase;
    logic [FrameBitsPerRow-1:0] rbFrame;

    frame_strobe_detect #(
        .Frames(MaxFramesPerCol)
    ) u_strobeDetect (
        .UserCLK    (UserCLK),
        .Reset      (Reset),
        .FrameStrobe(FrameStrobe),
        .writeOnehot(writeOnehot),
        .multiHot   (multiHot)
    );

    assign anyWrite = |writeOnehot;

    // Zero-padded full-column views; bits past NoConfigBits read back as 0.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        shadowPad = '0;
        activePad = '0;
        shadowPad[NoConfigBits-1:0] = shadow;
        activePad[NoConfigBits-1:0] = active;
    end

    always_comb begin
        shadowWrPad = shadowPad;
        for (int f = 0; f < MaxFramesPerCol; f++) begin
            if (writeOnehot[f]) begin
                shadowWrPad[f*FrameBitsPerRow +: FrameBitsPerRow] = FrameData;
            end
        end
    end

    always_comb begin
        rbSrcPad = ReadbackSrc ? shadowPad : activePad;
        rbBase   = PadIdxW'(ReadbackSel) * PadIdxW'(FrameBitsPerRow);
        rbFrame  = '0;
        if (int'(ReadbackSel) < MaxFramesPerCol) begin
            rbFrame = rbSrcPad[rbBase +: FrameBitsPerRow];
        end
    end

    // NOTE: shadow and active are plain flops rather than a RAM macro, so they
    // can take the asynchronous clear the configuration path depends on.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            shadow      <= '0;
            StrobeError <= 1'b0;
        end else begin
            shadow <= shadowWrPad[NoConfigBits-1:0];
            if (multiHot) begin
                StrobeError <= 1'b1;
            end
        end
    end

    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            ReadbackData  <= '0;
            ReadbackValid <= 1'b0;
        end else begin
            ReadbackValid <= ReadbackEn;
            if (ReadbackEn) begin
                ReadbackData <= rbFrame;
            end
        end
    end

    // Active loads the pre-edge shadow when leaving StCommit; a write landing on
    // that edge only reaches shadow and is remembered so the FSM returns to Dirty.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            state        <= StIdle;
            pendingWrite <= 1'b0;
            CommitAck    <= 1'b0;
            active       <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (CommitReq) begin
                        state <= StCommit;
                    end else if (anyWrite) begin
                        state <= StDirty;
                    end
                end
                StDirty: begin
                    if (CommitReq) begin
                        state <= StCommit;
                    end
                end
                StCommit: begin
                    active       <= shadow;
                    CommitAck    <= 1'b1;
                    pendingWrite <= anyWrite;
                    state        <= StAck;
                end
                StAck: begin
                    if (!CommitReq) begin
                        CommitAck    <= 1'b0;
                        pendingWrite <= 1'b0;
                        state        <= (pendingWrite || anyWrite) ? StDirty : StIdle;
                    end else if (anyWrite) begin
                        pendingWrite <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign ConfigBits   = active;
    assign ConfigBits_N = ~active;

endmodule

// File: tb/tb_tile_config_mem_shadow.sv
// Directed bench for tile_config_mem_shadow: a default-sized instance plus a
// NoConfigBits=40 instance sharing the same stimulus.
module tb_tile_config_mem_shadow;
    import tile_config_pkg::*;

    logic        UserCLK = 1'b0;
    logic        Reset;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic        CommitReq;
    logic        ReadbackEn;
    logic        ReadbackSrc;
    logic [4:0]  ReadbackSel;

    logic         ack0, rbValid0, strErr0;
    logic [31:0]  rbData0;
    logic [639:0] cfg0, cfgN0;
    logic         ack1, rbValid1, strErr1;
    logic [31:0]  rbData1;
    logic [39:0]  cfg1, cfgN1;

    int vecCount  = 0;
    int missCount = 0;

    always #5 UserCLK = ~UserCLK;

    tile_config_mem_shadow dut0 (
        .UserCLK(UserCLK), .Reset(Reset), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .CommitReq(CommitReq), .CommitAck(ack0), .ReadbackEn(ReadbackEn),
        .ReadbackSrc(ReadbackSrc), .ReadbackSel(ReadbackSel), .ReadbackData(rbData0),
        .ReadbackValid(rbValid0), .StrobeError(strErr0), .ConfigBits(cfg0), .ConfigBits_N(cfgN0)
    );

    tile_config_mem_shadow #(.NoConfigBits(40)) dut1 (
        .UserCLK(UserCLK), .Reset(Reset), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .CommitReq(CommitReq), .CommitAck(ack1), .ReadbackEn(ReadbackEn),
        .ReadbackSrc(ReadbackSrc), .ReadbackSel(ReadbackSel), .ReadbackData(rbData1),
        .ReadbackValid(rbValid1), .StrobeError(strErr1), .ConfigBits(cfg1), .ConfigBits_N(cfgN1)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge UserCLK);
        #1;
    endtask

    // Issue a one-cycle readback and leave outputs ready for sampling.
    task automatic readback(input logic src, input logic [4:0] sel);
        ReadbackEn  = 1'b1;
        ReadbackSrc = src;
        ReadbackSel = sel;
        tick();
        ReadbackEn  = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; FrameData = '0; FrameStrobe = '0; CommitReq = 1'b0;
        ReadbackEn = 1'b0; ReadbackSrc = 1'b0; ReadbackSel = '0;
        tick(); tick();
        checkVal("rst_cfg_lo",  64'(cfg0[63:0]), 64'h0);
        checkVal("rst_cfgn_hi", 64'(cfgN0[639:576]), 64'hFFFF_FFFF_FFFF_FFFF);
        checkVal("rst_ack",     64'(ack0), 64'h0);
        checkVal("rst_valid",   64'(rbValid0), 64'h0);
        checkVal("rst_strerr",  64'(strErr0), 64'h0);
        Reset = 1'b0;
        tick();

        // Shadow write without commit, then shadow readback.
        FrameData = 32'hA5A5_A5A5; FrameStrobe = 20'h1;
        tick();
        FrameStrobe = '0;
        checkVal("nocommit_cfg", 64'(cfg0[31:0]), 64'h0);
        readback(1'b1, 5'd0);
        checkVal("shadow_rb0_valid", 64'(rbValid0), 64'h1);
        checkVal("shadow_rb0_data",  64'(rbData0), 64'hA5A5_A5A5);
        tick();
        checkVal("valid_pulse", 64'(rbValid0), 64'h0);

        // Held strobe writes only on its rising edge.
        FrameData = 32'h1111_1111; FrameStrobe = 20'h4;
        tick();
        FrameData = 32'h2222_2222;
        tick();
        FrameStrobe = '0;
        tick();
        readback(1'b1, 5'd2);
        checkVal("held_strobe", 64'(rbData0), 64'h1111_1111);

        // Commit handshake.
        CommitReq = 1'b1;
        tick();
        checkVal("commit_ack_early", 64'(ack0), 64'h0);
        checkVal("commit_cfg_early", 64'(cfg0[31:0]), 64'h0);
        tick();
        checkVal("commit_ack",   64'(ack0), 64'h1);
        checkVal("commit_cfg0",  64'(cfg0[31:0]), 64'hA5A5_A5A5);
        checkVal("commit_cfgn0", 64'(cfgN0[31:0]), 64'h5A5A_5A5A);
        checkVal("commit_cfg2",  64'(cfg0[95:64]), 64'h1111_1111);
        tick();
        checkVal("ack_held", 64'(ack0), 64'h1);
        CommitReq = 1'b0;
        tick();
        checkVal("ack_drop",   64'(ack0), 64'h0);
        checkVal("state_idle", 64'(dut0.state), 64'(StIdle));
        readback(1'b0, 5'd0);
        checkVal("active_rb0", 64'(rbData0), 64'hA5A5_A5A5);

        // Write landing on the COMMIT edge goes to shadow only.
        CommitReq = 1'b1;
        tick();
        FrameData = 32'hDEAD_BEEF; FrameStrobe = 20'h2;
        tick();
        FrameStrobe = '0;
        checkVal("race_ack",  64'(ack0), 64'h1);
        checkVal("race_cfg1", 64'(cfg0[63:32]), 64'h0);
        CommitReq = 1'b0;
        tick();
        checkVal("race_ack_drop", 64'(ack0), 64'h0);
        checkVal("race_dirty",    64'(dut0.state), 64'(StDirty));
        readback(1'b1, 5'd1);
        checkVal("race_shadow1", 64'(rbData0), 64'hDEAD_BEEF);
        readback(1'b0, 5'd1);
        checkVal("race_active1", 64'(rbData0), 64'h0);

        // Reset in ACK aborts immediately.
        CommitReq = 1'b1;
        tick(); tick();
        checkVal("pre_rst_ack",  64'(ack0), 64'h1);
        checkVal("pre_rst_cfg1", 64'(cfg0[63:32]), 64'hDEAD_BEEF);
        Reset = 1'b1;
        #1;
        checkVal("async_rst_ack", 64'(ack0), 64'h0);
        checkVal("async_rst_cfg", 64'(cfg0[63:0]), 64'h0);
        CommitReq = 1'b0;
        tick();
        Reset = 1'b0;
        tick();

        // Multi-hot strobe rise: no write, sticky error.
        FrameData = 32'h1234_5678; FrameStrobe = 20'h3;
        tick();
        FrameStrobe = '0;
        checkVal("multihot_err", 64'(strErr0), 64'h1);
        readback(1'b1, 5'd0);
        checkVal("multihot_f0", 64'(rbData0), 64'h0);
        readback(1'b1, 5'd1);
        checkVal("multihot_f1", 64'(rbData0), 64'h0);
        checkVal("err_sticky",  64'(strErr0), 64'h1);
        Reset = 1'b1;
        #1;
        checkVal("err_cleared", 64'(strErr0), 64'h0);
        tick();
        Reset = 1'b0;
        tick();

        // Truncated instance: only bits 39:32 of frame 1 exist.
        FrameData = 32'hFFFF_FFFF; FrameStrobe = 20'h2;
        tick();
        FrameStrobe = '0;
        CommitReq = 1'b1;
        tick(); tick();
        checkVal("nb40_ack",    64'(ack1), 64'h1);
        checkVal("nb40_cfg",    64'(cfg1), 64'hFF_0000_0000);
        checkVal("nb40_cfgn",   64'(cfgN1), 64'h00_FFFF_FFFF);
        CommitReq = 1'b0;
        tick();
        readback(1'b0, 5'd1);
        checkVal("nb40_rb1",    64'(rbData1), 64'h0000_00FF);
        checkVal("full_rb1",    64'(rbData0), 64'hFFFF_FFFF);
        readback(1'b0, 5'd25);
        checkVal("oob_valid",   64'(rbValid1), 64'h1);
        checkVal("oob_data",    64'(rbData1), 64'h0);
        checkVal("oob_data_full", 64'(rbData0), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
